// File: rtl/bit_serializer_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word intake, one bit per en strobe on q.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module bit_serializer_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             q,
    output logic             q_valid,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             r_q_valid;
    logic             r_done;
`ifdef SERIALIZER_PARITY_EN
    logic             r_parity;
`endif

    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_din_rest;
    logic [WIDTH-1:0] w_shift_rest;

    // The shift register always holds the not-yet-sent bits, next one at the outgoing end.
    assign w_first_bit  = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign w_din_rest   = MSB_FIRST ? (din << 1) : (din >> 1);
    assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_shift_rest = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_q       <= 1'b0;
            r_q_valid <= 1'b0;
            r_done    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (din_valid) begin
                        r_shift   <= w_din_rest;
                        r_cnt     <= '0;
                        r_q       <= w_first_bit;
                        r_q_valid <= 1'b1;
                        r_state   <= S_SHIFT;
`ifdef SERIALIZER_PARITY_EN
                        r_parity  <= ^din;
`endif
                    end
                end
                S_SHIFT: begin
                    if (en) begin
                        if (r_cnt != LAST_CNT) begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_q     <= w_next_bit;
                            r_shift <= w_shift_rest;
                        end else begin
`ifdef SERIALIZER_PARITY_EN
                            r_state <= S_PARITY;
                            r_q     <= r_parity;
`else
                            r_state   <= S_IDLE;
                            r_q       <= 1'b0;
                            r_q_valid <= 1'b0;
                            r_done    <= 1'b1;
`endif
                        end
                    end
                end
                S_PARITY: begin
                    if (en) begin
                        r_state   <= S_IDLE;
                        r_q       <= 1'b0;
                        r_q_valid <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign din_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign q         = r_q;
    assign q_valid   = r_q_valid;
    assign done      = r_done;

endmodule

// File: tb/tb_bit_serializer_tx.sv
// Bench for bit_serializer_tx: MSB-first and LSB-first instances on shared stimulus,
// checked every cycle against a frame-level model plus literal bit-sequence pins.
module tb_bit_serializer_tx;
    localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         en        = 1'b0;
    logic         din_valid = 1'b0;
    logic [W-1:0] din       = '0;

    logic ma_ready, ma_q, ma_qv, ma_busy, ma_done;
    logic lb_ready, lb_q, lb_qv, lb_busy, lb_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bit_serializer_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .en(en), .din_valid(din_valid), .din(din),
        .din_ready(ma_ready), .q(ma_q), .q_valid(ma_qv), .busy(ma_busy), .done(ma_done)
    );

    bit_serializer_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .en(en), .din_valid(din_valid), .din(din),
        .din_ready(lb_ready), .q(lb_q), .q_valid(lb_qv), .busy(lb_busy), .done(lb_done)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: a frame is NB bits (data in send order, then parity); one bit per en edge.
    logic         md_busy = 1'b0;
    logic         md_done = 1'b0;
    logic [W-1:0] md_word = '0;
    int           md_pos  = 0;

    function automatic logic frame_bit(input logic [W-1:0] w, input int pos, input bit msb);
        logic [W-1:0] t;
        if (pos >= W) return ^w;
        t = msb ? (w >> (W - 1 - pos)) : (w >> pos);
        return t[0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            md_busy <= 1'b0;
            md_done <= 1'b0;
            md_pos  <= 0;
        end else begin
            md_done <= 1'b0;
            if (!md_busy) begin
                if (din_valid) begin
                    md_busy <= 1'b1;
                    md_word <= din;
                    md_pos  <= 0;
                end
            end else if (en) begin
                if (md_pos == NB - 1) begin
                    md_busy <= 1'b0;
                    md_done <= 1'b1;
                end else begin
                    md_pos <= md_pos + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("msb_outputs", 8'({ma_q, ma_qv, ma_done, ma_ready, ma_busy}),
            8'({md_busy & frame_bit(md_word, md_pos, 1'b1), md_busy, md_done, ~md_busy, md_busy}));
        chk("lsb_outputs", 8'({lb_q, lb_qv, lb_done, lb_ready, lb_busy}),
            8'({md_busy & frame_bit(md_word, md_pos, 1'b0), md_busy, md_done, ~md_busy, md_busy}));
    end

    task automatic wait_ready();
        int k = 0;
        while (!(ma_ready && lb_ready) && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("ready_timeout", 8'({ma_ready, lb_ready}), 8'b11);
    endtask

    // Sends one word with en=1 throughout and checks literal bit sequences (sm/sl written first bit leftmost).
    task automatic pin_frame(input logic [W-1:0] w, input logic [W-1:0] sm,
                             input logic [W-1:0] sl, input logic par);
        logic [W-1:0] tm;
        logic [W-1:0] tl;
        tm = sm;
        tl = sl;
        wait_ready();
        en        = 1'b1;
        din       = w;
        din_valid = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("pin_msb_bit", 8'({ma_qv, ma_q}), 8'({1'b1, tm[W-1]}));
            chk("pin_lsb_bit", 8'({lb_qv, lb_q}), 8'({1'b1, tl[W-1]}));
            tm = tm << 1;
            tl = tl << 1;
            #1 din_valid = 1'b0;
        end
`ifdef SERIALIZER_PARITY_EN
        @(negedge clk);
        chk("pin_msb_parity", 8'({ma_qv, ma_q}), 8'({1'b1, par}));
        chk("pin_lsb_parity", 8'({lb_qv, lb_q}), 8'({1'b1, par}));
`else
        if (par !== ^w) $display("note: parity literal for %h disagrees with data", w);
`endif
        @(negedge clk);
        chk("pin_msb_done", 8'({ma_done, ma_qv}), 8'b10);
        chk("pin_lsb_done", 8'({lb_done, lb_qv}), 8'b10);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Single word, en always high.
        pin_frame(8'hA5, 8'b10100101, 8'b10100101, 1'b0);
        pin_frame(8'h07, 8'b00000111, 8'b11100000, 1'b1);

        // en strobed every third cycle.
        wait_ready();
        din = 8'hA5;
        din_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            en = (c % 3 == 2);
            @(negedge clk);
            #1 din_valid = 1'b0;
        end

        // din_valid held with a new word arriving mid-frame: back-to-back frames.
        wait_ready();
        en = 1'b1;
        din = 8'hA5;
        din_valid = 1'b1;
        @(negedge clk);
        #1 din = 8'h3C;
        repeat (25) begin
            @(negedge clk);
            #1;
        end
        din_valid = 1'b0;

        // Reset mid-frame with no clock edge while it is asserted.
        wait_ready();
        din = 8'hFF;
        din_valid = 1'b1;
        @(negedge clk);
        #1 din_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_msb", 8'({ma_q, ma_qv, ma_done, ma_ready, ma_busy}), 8'b00010);
        chk("async_reset_lsb", 8'({lb_q, lb_qv, lb_done, lb_ready, lb_busy}), 8'b00010);
        #1 reset = 1'b0;
        pin_frame(8'h81, 8'b10000001, 8'b10000001, 1'b0);

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            #1;
            en        = ($urandom_range(0, 3) != 0);
            din_valid = ($urandom_range(0, 2) != 0);
            din       = W'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        en = 1'b0;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
